// File: rtl/is_uart_tx_fsm_pkg.sv
// rtl/is_uart_tx_fsm_pkg.sv - shared types and helpers for the UART transmit framer
package is_uart_tx_fsm_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TSYNC = 3'd1,
    TSTRB = 3'd2,
    TDT   = 3'd3,
    TPARB = 3'd4,
    TSTB1 = 3'd5,
    TSTB2 = 3'd6
  } state_t;

  // Parity bit that follows the data bits for a given mode (unused for PAR_NONE).
  function automatic logic parity_bit(input parity_t mode, input logic [UART_DATA_W-1:0] data);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/is_uart_tx_fsm_if.sv
// rtl/is_uart_tx_fsm_if.sv - byte handshake between a producer and the UART transmit framer
interface is_uart_tx_fsm_if;
  import is_uart_tx_fsm_pkg::*;

  logic [UART_DATA_W-1:0] tx_data_i;
  logic                   tx_valid_i;
  logic                   tx_ready_o;

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o
  );

endinterface

// File: rtl/is_uart_tx_fsm.sv
// rtl/is_uart_tx_fsm.sv - UART transmit framer: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits
// One bit per tx_ce_i baud tick; all outputs are registered.
module is_uart_tx_fsm
  import is_uart_tx_fsm_pkg::*;
#(
  parameter parity_t PARITY_MODE = PAR_SPACE,
  parameter int      STOP_BITS   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_ce_i,
  is_uart_tx_fsm_if.slave      tx,
  output logic                 txd_o,
  output logic                 txct_r_o,
  output logic                 tx_done_o
);

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $fatal(1, "is_uart_tx_fsm: STOP_BITS must be 1 or 2");
    end
  endgenerate

  state_t                 state, state_n;
  logic [UART_DATA_W-1:0] sh, sh_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic                   par, par_n;
  logic                   txd, txd_n;
  logic                   ready, ready_n;
  logic                   txct, txct_n;
  logic                   done, done_n;
  logic                   accept;

  assign accept = tx.tx_valid_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      txd     <= 1'b1;
      ready   <= 1'b1;
      txct    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bit_cnt <= bit_cnt_n;
      par     <= par_n;
      txd     <= txd_n;
      ready   <= ready_n;
      txct    <= txct_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    txd_n     = txd;
    ready_n   = ready;
    txct_n    = txct;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        // A tick coinciding with accept is deliberately ignored; the start bit waits for the next one.
        if (accept) begin
          sh_n    = tx.tx_data_i;
          par_n   = parity_bit(PARITY_MODE, tx.tx_data_i);
          ready_n = 1'b0;
          txct_n  = 1'b0;
          state_n = TSYNC;
        end
      end

      TSYNC: begin
        if (tx_ce_i) begin
          txd_n   = 1'b0;
          state_n = TSTRB;
        end
      end

      TSTRB: begin
        if (tx_ce_i) begin
          txd_n     = sh[0];
          sh_n      = {1'b0, sh[UART_DATA_W-1:1]};
          bit_cnt_n = 3'd1;
          state_n   = TDT;
        end
      end

      TDT: begin
        if (tx_ce_i) begin
          // bit_cnt wraps to zero once the eighth data bit has gone out.
          if (bit_cnt != 3'd0) begin
            txd_n     = sh[0];
            sh_n      = {1'b0, sh[UART_DATA_W-1:1]};
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (PARITY_MODE == PAR_NONE) begin
            txd_n   = 1'b1;
            state_n = TSTB1;
          end else begin
            txd_n   = par;
            state_n = TPARB;
          end
        end
      end

      TPARB: begin
        if (tx_ce_i) begin
          txd_n   = 1'b1;
          state_n = TSTB1;
        end
      end

      TSTB1: begin
        if (tx_ce_i) begin
          if (STOP_BITS == 2) begin
            state_n = TSTB2;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            ready_n = 1'b1;
            txct_n  = 1'b1;
          end
        end
      end

      TSTB2: begin
        if (tx_ce_i) begin
          state_n = IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
          txct_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        ready_n = 1'b1;
        txct_n  = 1'b1;
      end
    endcase
  end

  assign tx.tx_ready_o = ready;
  assign txd_o         = txd;
  assign txct_r_o      = txct;
  assign tx_done_o     = done;

endmodule

// File: tb/tb_is_uart_tx_fsm.sv
// tb/tb_is_uart_tx_fsm.sv - directed bench for the UART transmit framer across parity/stop configurations
`timescale 1ns/1ps
module tb_is_uart_tx_fsm;
  import is_uart_tx_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  // Instances: 0 default (space, 2 stop), 1 even, 2 odd, 3 mark, 4 none with 1 stop.
  logic [7:0] data_a [5];
  logic [4:0] valid_v = '0;
  logic [4:0] rdy_v, txd_v, txct_v, done_v;

  int vectors = 0;
  int errors  = 0;

  is_uart_tx_fsm_if bus0 ();
  is_uart_tx_fsm_if bus1 ();
  is_uart_tx_fsm_if bus2 ();
  is_uart_tx_fsm_if bus3 ();
  is_uart_tx_fsm_if bus4 ();

  assign bus0.tx_data_i = data_a[0];  assign bus0.tx_valid_i = valid_v[0];  assign rdy_v[0] = bus0.tx_ready_o;
  assign bus1.tx_data_i = data_a[1];  assign bus1.tx_valid_i = valid_v[1];  assign rdy_v[1] = bus1.tx_ready_o;
  assign bus2.tx_data_i = data_a[2];  assign bus2.tx_valid_i = valid_v[2];  assign rdy_v[2] = bus2.tx_ready_o;
  assign bus3.tx_data_i = data_a[3];  assign bus3.tx_valid_i = valid_v[3];  assign rdy_v[3] = bus3.tx_ready_o;
  assign bus4.tx_data_i = data_a[4];  assign bus4.tx_valid_i = valid_v[4];  assign rdy_v[4] = bus4.tx_ready_o;

  is_uart_tx_fsm dut0 (.clk_i(clk), .rst_i(rst), .tx_ce_i(ce), .tx(bus0.slave),
                       .txd_o(txd_v[0]), .txct_r_o(txct_v[0]), .tx_done_o(done_v[0]));
  is_uart_tx_fsm #(.PARITY_MODE(PAR_EVEN)) dut1 (.clk_i(clk), .rst_i(rst), .tx_ce_i(ce), .tx(bus1.slave),
                       .txd_o(txd_v[1]), .txct_r_o(txct_v[1]), .tx_done_o(done_v[1]));
  is_uart_tx_fsm #(.PARITY_MODE(PAR_ODD)) dut2 (.clk_i(clk), .rst_i(rst), .tx_ce_i(ce), .tx(bus2.slave),
                       .txd_o(txd_v[2]), .txct_r_o(txct_v[2]), .tx_done_o(done_v[2]));
  is_uart_tx_fsm #(.PARITY_MODE(PAR_MARK)) dut3 (.clk_i(clk), .rst_i(rst), .tx_ce_i(ce), .tx(bus3.slave),
                       .txd_o(txd_v[3]), .txct_r_o(txct_v[3]), .tx_done_o(done_v[3]));
  is_uart_tx_fsm #(.PARITY_MODE(PAR_NONE), .STOP_BITS(1)) dut4 (.clk_i(clk), .rst_i(rst), .tx_ce_i(ce), .tx(bus4.slave),
                       .txd_o(txd_v[4]), .txct_r_o(txct_v[4]), .tx_done_o(done_v[4]));

  task automatic tick();
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
  endtask

  task automatic accept(input int k, input logic [7:0] b);
    @(negedge clk); data_a[k] = b; valid_v[k] = 1'b1;
    @(negedge clk); valid_v[k] = 1'b0;
    vectors++;
    if ({rdy_v[k], txct_v[k], txd_v[k]} !== 3'b001) begin
      errors++;
      $display("FAIL accept inst%0d: ready/txct/txd=%b required 001", k, {rdy_v[k], txct_v[k], txd_v[k]});
    end
  endtask

  // Expected line sequence: start, b[0..7], optional parity, stop bit(s); one tick each, then a finishing tick.
  task automatic run_frame(input int k, input logic [7:0] b, input bit has_par, input bit pb,
                           input int nstop, input string nm);
    logic [11:0] exp_bits;
    int n;
    exp_bits = '0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    n = 9;
    if (has_par) begin exp_bits[n] = pb; n++; end
    for (int s = 0; s < nstop; s++) begin exp_bits[n] = 1'b1; n++; end
    for (int i = 0; i < n; i++) begin
      tick();
      vectors++;
      if ({txd_v[k], rdy_v[k], done_v[k]} !== {exp_bits[i], 2'b00}) begin
        errors++;
        $display("FAIL %s bit%0d: txd/ready/done=%b required %b", nm, i,
                 {txd_v[k], rdy_v[k], done_v[k]}, {exp_bits[i], 2'b00});
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (txd_v[k] !== exp_bits[i]) begin
        errors++;
        $display("FAIL %s hold bit%0d: txd=%b required %b", nm, i, txd_v[k], exp_bits[i]);
      end
    end
    tick();
    vectors++;
    if ({done_v[k], rdy_v[k], txct_v[k], txd_v[k]} !== 4'b1111) begin
      errors++;
      $display("FAIL %s finish: done/ready/txct/txd=%b required 1111", nm,
               {done_v[k], rdy_v[k], txct_v[k], txd_v[k]});
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({txd_v, rdy_v, txct_v, done_v} !== {5'h1f, 5'h1f, 5'h1f, 5'h00}) begin
      errors++;
      $display("FAIL reset_values: txd/rdy/txct/done=%b required %b", {txd_v, rdy_v, txct_v, done_v},
               {5'h1f, 5'h1f, 5'h1f, 5'h00});
    end
    @(negedge clk); rst = 1'b0;
    // Mid-frame reset: drive partway into a frame of zeros so txd is low, then reset.
    accept(0, 8'h00);
    repeat (4) tick();
    vectors++;
    if (txd_v[0] !== 1'b0) begin
      errors++; $display("FAIL midframe_pre: txd=%b required 0", txd_v[0]);
    end
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if ({txd_v[0], rdy_v[0], txct_v[0], done_v[0]} !== 4'b1110) begin
      errors++;
      $display("FAIL midframe_reset: txd/ready/txct/done=%b required 1110", {txd_v[0], rdy_v[0], txct_v[0], done_v[0]});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({txd_v[0], rdy_v[0], txct_v[0], done_v[0]} !== 4'b1110) begin
      errors++;
      $display("FAIL after_reset: txd/ready/txct/done=%b required 1110", {txd_v[0], rdy_v[0], txct_v[0], done_v[0]});
    end
  endtask

  task automatic test_default_a5();
    accept(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b1, 1'b0, 2, "default_a5");
    @(negedge clk);
    vectors++;
    if (done_v[0] !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: done=%b required 0", done_v[0]);
    end
  endtask

  task automatic test_parity();
    accept(1, 8'hA5); run_frame(1, 8'hA5, 1'b1, 1'b0, 2, "even_a5");
    accept(2, 8'hA5); run_frame(2, 8'hA5, 1'b1, 1'b1, 2, "odd_a5");
    accept(3, 8'hA5); run_frame(3, 8'hA5, 1'b1, 1'b1, 2, "mark_a5");
    accept(1, 8'h07); run_frame(1, 8'h07, 1'b1, 1'b1, 2, "even_07");
    accept(2, 8'h07); run_frame(2, 8'h07, 1'b1, 1'b0, 2, "odd_07");
    accept(3, 8'h07); run_frame(3, 8'h07, 1'b1, 1'b1, 2, "mark_07");
  endtask

  task automatic test_none_one_stop();
    accept(4, 8'h3C);
    run_frame(4, 8'h3C, 1'b0, 1'b0, 1, "none_3c");
  endtask

  task automatic test_accept_on_tick();
    @(negedge clk); data_a[0] = 8'h81; valid_v[0] = 1'b1; ce = 1'b1;
    @(negedge clk); valid_v[0] = 1'b0; ce = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rdy_v[0], txct_v[0], txd_v[0]} !== 3'b001) begin
      errors++;
      $display("FAIL accept_on_tick: ready/txct/txd=%b required 001", {rdy_v[0], txct_v[0], txd_v[0]});
    end
    run_frame(0, 8'h81, 1'b1, 1'b0, 2, "accept_on_tick");
  endtask

  task automatic test_back_to_back();
    accept(0, 8'h5A);
    // Keep offering a different byte throughout; it must be ignored until the frame completes.
    @(negedge clk); data_a[0] = 8'hC3; valid_v[0] = 1'b1;
    run_frame(0, 8'h5A, 1'b1, 1'b0, 2, "b2b_first");
    @(negedge clk); valid_v[0] = 1'b0;
    vectors++;
    if ({rdy_v[0], txct_v[0], done_v[0], txd_v[0]} !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_accept: ready/txct/done/txd=%b required 0001", {rdy_v[0], txct_v[0], done_v[0], txd_v[0]});
    end
    run_frame(0, 8'hC3, 1'b1, 1'b0, 2, "b2b_second");
  endtask

  task automatic test_random_bytes();
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      accept(0, b);
      run_frame(0, b, 1'b1, 1'b0, 2, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) data_a[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_default_a5();
    test_parity();
    test_none_one_stop();
    test_accept_on_tick();
    test_back_to_back();
    test_random_bytes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion within 2 ms");
    $fatal(1, "timeout");
  end

endmodule
